reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- Architectural integer register file for the single-cycle RISC-V core; sits directly upstream of the ALU.
- Read ports 1 and 2 drive the ALU operands DATA_A and DATA_B. The write port takes the selected writeback value (ALU OUT, memory load data or PC+4).
- Provides 2 asynchronous read ports, 1 synchronous write port and a debug read port, with x0 hardwired to zero.
- Optional write-to-read bypass, for use when the core is later pipelined.

Parameters:
- WIDTH, 32, data width of every register and port.
- ADDR_W, 5, register address width; the number of registers is 2**ADDR_W.
- BYPASS, 0, when 1, a read of the register being written this cycle returns the write data.

Ports:
- CLK  input  1  core clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- WE  input  1  write enable for the write port.
- WA  input  ADDR_W  write address.
- WD  input  WIDTH  write data.
- RA1  input  ADDR_W  read address, port 1.
- RD1  output  WIDTH  read data, port 1; feeds ALU DATA_A.
- RA2  input  ADDR_W  read address, port 2.
- RD2  output  WIDTH  read data, port 2; feeds ALU DATA_B.
- DBG_A  input  ADDR_W  debug/testbench read address.
- DBG_D  output  WIDTH  debug read data.

Behaviour:
- Storage: registers 1 to 2**ADDR_W-1, each WIDTH bits. Register 0 has no storage.
- Reset: on a rising edge with RESET low, every stored register becomes 0.
  - Reset has priority over a write in the same cycle; that write is discarded.
  - Reset asserted mid-program clears all registers at that edge.
- Write: on a rising edge with RESET high, WE high and WA != 0, reg[WA] <= WD.
  - WE low: no state change.
  - WA == 0: silently ignored.
  - WD and WA must be stable only around the clock edge.
- Read: combinational, with zero cycles of latency.
  - RDn = 0 if RAn == 0, otherwise reg[RAn].
  - DBG_D follows the same rule using DBG_A.
  - A write becomes visible on RD1, RD2 and DBG_D in the cycle after the edge that performs it.
- Bypass (BYPASS=1 only): if WE=1, WA != 0 and RAn == WA, then RDn = WD in the same cycle.
  - The same rule applies to DBG_D.
  - When RESET is low, bypass is suppressed and reads return the stored value.
- Port independence:
  - RA1 == RA2 returns identical data on both ports.
  - All three read ports may address any register simultaneously.
- Outputs during reset:
  - While RESET is low, the outputs reflect pre-reset contents until the edge.
  - After the edge, every read returns 0.
- X handling: no X may propagate to any read port after the first reset edge.
- Width rules:
  - Addresses are unsigned.
  - There is no sign extension or truncation inside the block; WD is stored exactly as presented.

Decomposition:
- Shared core package holds:
  - XLEN = 32, REG_ADDR_W = 5.
  - ZERO_REG = 5'd0.
  - Named ABI register indices (RA_REG = 1, SP_REG = 2, ...) for benches and the decoder.
- No sub-module: the storage array, write logic and three read muxes are simple enough to stay in one module.
- The read-mux function (zero check plus optional bypass) is written once and reused for all three read ports.

Test Plan:
- Write, then read: reset low for 1 cycle; write WA=5, WD=0xDEADBEEF with WE=1 -> next cycle RA1=5 gives RD1=0xDEADBEEF, and RA2=5 gives RD2=0xDEADBEEF.
- x0 immutability: write WA=0, WD=0xFFFFFFFF -> RD1 (RA1=0) = 0 and DBG_D (DBG_A=0) = 0 on all following cycles.
- Write-enable gating: write x7 = 0x12345678, then WE=0 with WA=7, WD=0xAAAAAAAA -> RD2 (RA2=7) stays 0x12345678.
- Bypass:
  - BYPASS=1: WE=1, WA=9, WD=0x00000042, RA1=9 in the same cycle -> RD1=0x00000042 before the edge.
  - BYPASS=0, same stimulus -> RD1 holds the old value (0) until after the edge.
- Reset mid-operation: fill x1 to x31 with index*0x01010101; assert RESET low together with WE=1, WA=3 -> after the edge every DBG_D read for x1 to x31 is 0, including x3.
- Sweep: write x1 to x31 with distinct values, then read all pairs through RA1/RA2 -> every read matches the shadow model, and x0 always reads 0.

Source files
------------

// File: rtl/reg_file_2r1w_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_2r1w_pkg
//   Shared core constants for the integer register file and its users
//   (decoder, benches). Holds the architectural widths, the zero register
//   index and the RISC-V ABI names of the integer registers.
// ---------------------------------------------------------------------------
package reg_file_2r1w_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // ABI register indices (x0..x31)
    typedef enum logic [REG_ADDR_W-1:0] {
        X0_REG  = 5'd0,  RA_REG  = 5'd1,  SP_REG  = 5'd2,  GP_REG  = 5'd3,
        TP_REG  = 5'd4,  T0_REG  = 5'd5,  T1_REG  = 5'd6,  T2_REG  = 5'd7,
        S0_REG  = 5'd8,  S1_REG  = 5'd9,  A0_REG  = 5'd10, A1_REG  = 5'd11,
        A2_REG  = 5'd12, A3_REG  = 5'd13, A4_REG  = 5'd14, A5_REG  = 5'd15,
        A6_REG  = 5'd16, A7_REG  = 5'd17, S2_REG  = 5'd18, S3_REG  = 5'd19,
        S4_REG  = 5'd20, S5_REG  = 5'd21, S6_REG  = 5'd22, S7_REG  = 5'd23,
        S8_REG  = 5'd24, S9_REG  = 5'd25, S10_REG = 5'd26, S11_REG = 5'd27,
        T3_REG  = 5'd28, T4_REG  = 5'd29, T5_REG  = 5'd30, T6_REG  = 5'd31
    } abi_reg_e;

endpackage : reg_file_2r1w_pkg

// File: rtl/reg_file_2r1w.sv
// ---------------------------------------------------------------------------
// reg_file_2r1w
//   Architectural integer register file: two combinational read ports feeding
//   the ALU operands, one synchronous write port for the writeback value, and
//   a combinational debug read port. x0 has no storage and always reads 0.
//   Optional write-to-read bypass (BYPASS=1) for a future pipelined core.
//
// Ports
//   CLK    in   1       core clock, rising edge
//   RESET  in   1       synchronous active-low reset (clears x1..xN-1)
//   WE     in   1       write enable
//   WA     in   ADDR_W  write address
//   WD     in   WIDTH   write data
//   RA1    in   ADDR_W  read address, port 1
//   RD1    out  WIDTH   read data, port 1 (ALU DATA_A)
//   RA2    in   ADDR_W  read address, port 2
//   RD2    out  WIDTH   read data, port 2 (ALU DATA_B)
//   DBG_A  in   ADDR_W  debug read address
//   DBG_D  out  WIDTH   debug read data
// ---------------------------------------------------------------------------
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [WIDTH-1:0]  WD,
    input  logic [ADDR_W-1:0] RA1,
    output logic [WIDTH-1:0]  RD1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [WIDTH-1:0]  RD2,
    input  logic [ADDR_W-1:0] DBG_A,
    output logic [WIDTH-1:0]  DBG_D
);

    localparam int NREG = 1 << ADDR_W;

    // Storage exists only for x1..x(NREG-1)
    logic [WIDTH-1:0] regs_q [1:NREG-1];
    logic [WIDTH-1:0] regs_d [1:NREG-1];

    // Read view with a constant-zero entry 0 so every read index is in range
    logic [WIDTH-1:0] rd_view [0:NREG-1];

    // A write that would actually land this cycle; WA==0 never qualifies
    logic wr_hit;
    assign wr_hit = WE && (WA != '0);

    assign rd_view[0] = '0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
            assign regs_d[gi]  = (wr_hit && (WA == ADDR_W'(gi))) ? WD : regs_q[gi];
            assign rd_view[gi] = regs_q[gi];
        end
    endgenerate

    // Reset wins over a same-cycle write
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Shared read mux: x0 forces zero; bypass forwards WD only while out of
    // reset, so reads during a reset cycle show the stored (pre-reset) value.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  stored,
        input logic              hit,
        input logic [ADDR_W-1:0] waddr,
        input logic [WIDTH-1:0]  wdata,
        input logic              rst_n
    );
        logic [WIDTH-1:0] val;
        val = stored;
        if (addr == '0) begin
            val = '0;
        end else if ((BYPASS != 0) && rst_n && hit && (addr == waddr)) begin
            val = wdata;
        end
        return val;
    endfunction

    assign RD1   = read_port(RA1,   rd_view[RA1],   wr_hit, WA, WD, RESET);
    assign RD2   = read_port(RA2,   rd_view[RA2],   wr_hit, WA, WD, RESET);
    assign DBG_D = read_port(DBG_A, rd_view[DBG_A], wr_hit, WA, WD, RESET);

endmodule : reg_file_2r1w

// File: tb/tb_reg_file_2r1w.sv
// ---------------------------------------------------------------------------
// tb_reg_file_2r1w
//   Directed bench for reg_file_2r1w. Two instances share all inputs: one
//   without bypass (nb) and one with bypass (b). Inputs change #1 after the
//   rising edge; outputs are sampled a further #1 later, away from the edge.
// ---------------------------------------------------------------------------
module tb_reg_file_2r1w;

    localparam int W = 32;
    localparam int A = 5;

    logic         CLK;
    logic         RESET;
    logic         WE;
    logic [A-1:0] WA;
    logic [W-1:0] WD;
    logic [A-1:0] RA1;
    logic [A-1:0] RA2;
    logic [A-1:0] DBG_A;

    logic [W-1:0] nb_rd1, nb_rd2, nb_dbg;
    logic [W-1:0] b_rd1,  b_rd2,  b_dbg;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] shadow [0:31];

    reg_file_2r1w #(.WIDTH(W), .ADDR_W(A), .BYPASS(0)) u_dut_nb (
        .CLK(CLK), .RESET(RESET), .WE(WE), .WA(WA), .WD(WD),
        .RA1(RA1), .RD1(nb_rd1), .RA2(RA2), .RD2(nb_rd2),
        .DBG_A(DBG_A), .DBG_D(nb_dbg)
    );

    reg_file_2r1w #(.WIDTH(W), .ADDR_W(A), .BYPASS(1)) u_dut_b (
        .CLK(CLK), .RESET(RESET), .WE(WE), .WA(WA), .WD(WD),
        .RA1(RA1), .RD1(b_rd1), .RA2(RA2), .RD2(b_rd2),
        .DBG_A(DBG_A), .DBG_D(b_dbg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs may then be changed safely
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0; WE = 1'b0; WA = '0; WD = '0;
        RA1 = '0; RA2 = '0; DBG_A = '0;

        // ---- reset state -------------------------------------------------
        tick();
        RESET = 1'b1; RA1 = 5'd5; RA2 = 5'd1; DBG_A = 5'd31;
        #1;
        chk("reset_rd1_x5",   nb_rd1, 32'h0);
        chk("reset_rd2_x1",   nb_rd2, 32'h0);
        chk("reset_dbg_x31",  nb_dbg, 32'h0);
        chk("reset_b_dbg_x31", b_dbg, 32'h0);

        // ---- bypass: x9 <= 0x42, read in same cycle ----------------------
        WE = 1'b1; WA = 5'd9; WD = 32'h0000_0042; RA1 = 5'd9; DBG_A = 5'd9;
        #1;
        chk("nobyp_rd1_before_edge", nb_rd1, 32'h0);
        chk("byp_rd1_before_edge",   b_rd1,  32'h0000_0042);
        chk("byp_dbg_before_edge",   b_dbg,  32'h0000_0042);
        chk("nobyp_dbg_before_edge", nb_dbg, 32'h0);
        tick();
        WE = 1'b0;
        #1;
        chk("nobyp_rd1_after_edge", nb_rd1, 32'h0000_0042);
        chk("byp_rd1_after_edge",   b_rd1,  32'h0000_0042);

        // ---- write then read: x5 <= DEADBEEF -----------------------------
        WE = 1'b1; WA = 5'd5; WD = 32'hDEAD_BEEF; RA1 = 5'd5; RA2 = 5'd5;
        #1;
        chk("nobyp_rd1_x5_pre", nb_rd1, 32'h0);
        tick();
        WE = 1'b0; WD = 32'h0;
        #1;
        chk("wr_rd1_x5",   nb_rd1, 32'hDEAD_BEEF);
        chk("wr_rd2_x5",   nb_rd2, 32'hDEAD_BEEF);
        chk("wr_b_rd1_x5", b_rd1,  32'hDEAD_BEEF);
        chk("wr_b_rd2_x5", b_rd2,  32'hDEAD_BEEF);

        // ---- x0 immutability ---------------------------------------------
        WE = 1'b1; WA = 5'd0; WD = 32'hFFFF_FFFF; RA1 = 5'd0; DBG_A = 5'd0;
        #1;
        chk("x0_b_rd1_same_cycle", b_rd1, 32'h0);
        chk("x0_b_dbg_same_cycle", b_dbg, 32'h0);
        tick();
        WE = 1'b0;
        #1;
        chk("x0_rd1_cyc1",  nb_rd1, 32'h0);
        chk("x0_dbg_cyc1",  nb_dbg, 32'h0);
        tick();
        chk("x0_rd1_cyc2",  nb_rd1, 32'h0);
        chk("x0_dbg_cyc2",  b_dbg,  32'h0);
        RA1 = 5'd5;
        #1;
        chk("x0_write_no_alias_x5", nb_rd1, 32'hDEAD_BEEF);

        // ---- write-enable gating on x7 -----------------------------------
        WE = 1'b1; WA = 5'd7; WD = 32'h1234_5678; RA2 = 5'd7;
        tick();
        WE = 1'b0; WA = 5'd7; WD = 32'hAAAA_AAAA;
        #1;
        chk("we_gate_rd2_pre",   nb_rd2, 32'h1234_5678);
        chk("we_gate_b_rd2_pre", b_rd2,  32'h1234_5678);
        tick();
        chk("we_gate_rd2_post",   nb_rd2, 32'h1234_5678);
        chk("we_gate_b_rd2_post", b_rd2,  32'h1234_5678);

        // ---- sweep: distinct values in x1..x31, read all pairs -----------
        shadow[0] = 32'h0;
        for (int i = 1; i < 32; i++) begin
            shadow[i] = (i * 32'h0001_0203) ^ 32'hC300_0000;
            WE = 1'b1; WA = A'(i); WD = shadow[i];
            tick();
        end
        WE = 1'b0; WA = '0; WD = '0;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                RA1 = A'(i); RA2 = A'(j);
                #1;
                chk($sformatf("sweep_rd1_x%0d", i),   nb_rd1, shadow[i]);
                chk($sformatf("sweep_rd2_x%0d", j),   nb_rd2, shadow[j]);
                chk($sformatf("sweep_b_rd1_x%0d", i), b_rd1,  shadow[i]);
                chk($sformatf("sweep_b_rd2_x%0d", j), b_rd2,  shadow[j]);
            end
        end

        // ---- reset mid-operation -----------------------------------------
        tick();
        for (int i = 1; i < 32; i++) begin
            shadow[i] = i * 32'h0101_0101;
            WE = 1'b1; WA = A'(i); WD = shadow[i];
            tick();
        end
        WE = 1'b1; WA = 5'd3; WD = 32'hFFFF_FFFF; RESET = 1'b0;
        DBG_A = 5'd3; RA1 = 5'd3; RA2 = 5'd31;
        #1;
        chk("rst_pre_b_dbg_x3",  b_dbg,  32'h0303_0303);
        chk("rst_pre_b_rd1_x3",  b_rd1,  32'h0303_0303);
        chk("rst_pre_rd2_x31",   nb_rd2, 32'h1F1F_1F1F);
        tick();
        RESET = 1'b1; WE = 1'b0;
        for (int i = 1; i < 32; i++) begin
            DBG_A = A'(i);
            #1;
            chk($sformatf("rst_post_dbg_x%0d", i),   nb_dbg, 32'h0);
            chk($sformatf("rst_post_b_dbg_x%0d", i), b_dbg,  32'h0);
        end
        chk("rst_post_rd1_x3", nb_rd1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_file_2r1w
